decode_stage: RTL and testbench
===============================

# decode_stage

Instruction decode and issue stage of the rv32i core, sitting between fetch and execute and driving the read ports of the register file. Holds one instruction, drives its source register addresses to the register file, and builds the immediate. Tracks in-flight destination registers in a 31-entry scoreboard and stalls on read-after-write and write-after-write hazards. Issues operand bundles to execute over a valid/ready handshake.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- i_clk  in  1  clock; all state updates on posedge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_if_valid / o_if_ready  in/out  1  fetch handshake.
- i_if_instr, i_if_pc  in  32  instruction word and its PC.
- o_r1addr, o_r2addr  out  5  register file read addresses, equal to IR[19:15] and IR[24:20].
- i_r1data, i_r2data  in  32  register file read data; updated at each negedge, reads x0 as 0.
- o_ex_valid / i_ex_ready  out/in  1  execute handshake.
- o_ex_pc, o_ex_rs1val, o_ex_rs2val, o_ex_imm  out  32  issued PC, operands and immediate.
- o_ex_rd  out  5  destination register; 0 when the instruction writes no register.
- o_ex_opcode  out  7  opcode field.
- o_ex_funct3  out  3  funct3 field.
- o_ex_funct7b5  out  1  instruction bit 30.
- o_ex_illegal  out  1  opcode not in RV32I base set.
- i_wb_en, i_wb_rd  in  1/5  writeback occurring this cycle, and its register.
- i_flush  in  1  redirect; discards the held instruction.

## Operation
- State: IR (instr, pc), ir_valid, busy[31:1].
- uses_rs1 is false for LUI, AUIPC and JAL. uses_rs2 is true only for BRANCH, STORE and OP.
- writes_rd is false for BRANCH, STORE, FENCE, SYSTEM and illegal instructions. Otherwise writes_rd = (rd != 0).
- stall = (uses_rs1 & busy[rs1]) | (uses_rs2 & busy[rs2]) | (writes_rd & busy[rd]). Busy checks for x0 are always false.
- o_ex_valid = ir_valid & !stall & !i_flush.
- fire = o_ex_valid & i_ex_ready.
- o_if_ready = !i_flush & (!ir_valid | fire).
- Fetch accept (i_if_valid & o_if_ready): load IR and set ir_valid.
- Fire without accept: clear ir_valid.
- Fire with writes_rd: set busy[rd].
- i_wb_en with i_wb_rd != 0: clear busy[i_wb_rd].
- Simultaneous set and clear of the same bit: set wins.
- Immediate types by opcode:
  - I (LOAD, OP-IMM, JALR, SYSTEM).
  - S (STORE).
  - B (BRANCH), bit 0 = 0.
  - U (LUI, AUIPC), low 12 bits = 0.
  - J (JAL), bit 0 = 0.
  - All are sign-extended from instr[31]. Illegal and FENCE give 0.
- Illegal instructions still issue with o_ex_illegal = 1 and o_ex_rd = 0.
- i_flush: clear ir_valid; no issue and no accept this cycle. The scoreboard is untouched because older in-flight writebacks still complete.

## Timing
- In reset (i_rst_n low) and on the first cycle after it:
  - ir_valid = 0, busy = 0.
  - o_ex_valid = 0, o_if_ready = 0 while in reset.
  - Data outputs are don't-care with valid low.
- Latency: an instruction accepted at posedge N is presented during cycle N+1 and can fire at posedge N+1. Throughput is 1 per cycle.
- Operand data: addresses are registered, so i_r*data is valid from the negedge of cycle N+1 onward.
- While o_ex_valid & !i_ex_ready, all o_ex_* outputs stay stable. Sources are not busy, so i_r*data cannot change.
- Writeback bypass: none. The register file writes at the negedge of the i_wb_en cycle, and a same-negedge read returns the old value.
  - busy clears at the posedge ending that cycle.
  - The dependent instruction reads at the next negedge and fires at the end of that cycle.
  - The RAW bubble is therefore at least 1 cycle after writeback.
- Back-to-back dependents (rs1 == previous rd) stall until the matching i_wb_en.

## Structure
- rv32i_pkg holds:
  - opcode localparams: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, FENCE, SYSTEM;
  - the imm_type_t enum (I, S, B, U, J, NONE).
- Sub-module imm_gen is purely combinational: instr to imm. The scoreboard stays inline.

## Test plan
- ADDI x1,x0,5 (0x00500093) issued with ready=1 -> o_ex_imm=5, o_ex_rd=1, busy[1] set; one-cycle latency from accept.
- ADD x2,x1,x1 issued right after it -> o_ex_valid=0 and o_if_ready=0 until i_wb_en with rd=1. The instruction fires one cycle after the writeback cycle, with rs1val=rs2val=5.
- i_ex_ready held low 3 cycles with BEQ imm=-4 -> o_ex_imm=0xFFFFFFFC, outputs stable, o_if_ready=0, and o_ex_rd=0 on fire.
- i_wb_en rd=3 in the same cycle an instruction with rd=3 fires -> busy[3] remains 1.
- i_flush with a stalled instruction in IR -> ir_valid=0 next cycle, no fire, and busy bits unchanged.
- Opcode 0x7F -> fires with o_ex_illegal=1, o_ex_rd=0, imm=0. Reset asserted mid-stall -> all busy cleared and o_ex_valid=0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: base opcodes, immediate formats and
// small opcode classification helpers used by the decode stage.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ImmI,
        ImmS,
        ImmB,
        ImmU,
        ImmJ,
        ImmNone
    } imm_type_t;

    function automatic imm_type_t imm_type_of(input logic [6:0] opcode);
        imm_type_t t;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: t = ImmI;
            OPC_STORE:                                  t = ImmS;
            OPC_BRANCH:                                 t = ImmB;
            OPC_LUI, OPC_AUIPC:                         t = ImmU;
            OPC_JAL:                                    t = ImmJ;
            default:                                    t = ImmNone;
        endcase
        return t;
    endfunction

    function automatic logic is_legal(input logic [6:0] opcode);
        logic ok;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_FENCE, OPC_SYSTEM: ok = 1'b1;
            default:                                              ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate builder: sign-extends from instr[31] according to
// the instruction format; FENCE and unknown opcodes yield zero.
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [31:0] o_imm
);

    imm_type_t imm_type;
    logic      sign;

    always_comb begin
        imm_type = imm_type_of(i_instr[6:0]);
        sign     = i_instr[31];
        o_imm    = 32'h0;
        case (imm_type)
            ImmI: o_imm = {{20{sign}}, i_instr[31:20]};
            ImmS: o_imm = {{20{sign}}, i_instr[31:25], i_instr[11:7]};
            ImmB: o_imm = {{19{sign}}, sign, i_instr[7], i_instr[30:25],
                           i_instr[11:8], 1'b0};
            ImmU: o_imm = {i_instr[31:12], 12'h000};
            ImmJ: o_imm = {{11{sign}}, sign, i_instr[19:12], i_instr[20],
                           i_instr[30:21], 1'b0};
            default: o_imm = 32'h0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode/issue stage: holds one instruction, stalls on RAW/WAW hazards
// against a scoreboard of in-flight destinations, and issues to execute.
module decode_stage
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,

    input  logic            i_if_valid,
    output logic            o_if_ready,
    input  logic [31:0]     i_if_instr,
    input  logic [XLEN-1:0] i_if_pc,

    output logic [4:0]      o_r1addr,
    output logic [4:0]      o_r2addr,
    input  logic [XLEN-1:0] i_r1data,
    input  logic [XLEN-1:0] i_r2data,

    output logic            o_ex_valid,
    input  logic            i_ex_ready,
    output logic [XLEN-1:0] o_ex_pc,
    output logic [XLEN-1:0] o_ex_rs1val,
    output logic [XLEN-1:0] o_ex_rs2val,
    output logic [XLEN-1:0] o_ex_imm,
    output logic [4:0]      o_ex_rd,
    output logic [6:0]      o_ex_opcode,
    output logic [2:0]      o_ex_funct3,
    output logic            o_ex_funct7b5,
    output logic            o_ex_illegal,

    input  logic            i_wb_en,
    input  logic [4:0]      i_wb_rd,
    input  logic            i_flush
);

    logic [31:0]     ir_instr_q, ir_instr_d;
    logic [XLEN-1:0] ir_pc_q, ir_pc_d;
    logic            ir_valid_q, ir_valid_d;
    logic [31:1]     busy_q, busy_d;

    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic        legal;
    logic        uses_rs1, uses_rs2, writes_rd;
    logic [31:0] busy_ext;
    logic        stall;
    logic        fire, accept;
    logic [31:0] imm;

    imm_gen u_imm_gen (
        .i_instr (ir_instr_q),
        .o_imm   (imm)
    );

    always_comb begin
        opcode    = ir_instr_q[6:0];
        rs1       = ir_instr_q[19:15];
        rs2       = ir_instr_q[24:20];
        rd        = ir_instr_q[11:7];
        legal     = is_legal(opcode);

        uses_rs1  = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
        uses_rs2  = (opcode == OPC_BRANCH || opcode == OPC_STORE || opcode == OPC_OP);
        writes_rd = legal && (rd != 5'd0) &&
                    !(opcode == OPC_BRANCH || opcode == OPC_STORE ||
                      opcode == OPC_FENCE  || opcode == OPC_SYSTEM);

        // Bit 0 is tied low so x0 never reads as busy.
        busy_ext  = {busy_q, 1'b0};
        stall     = (uses_rs1 & busy_ext[rs1]) |
                    (uses_rs2 & busy_ext[rs2]) |
                    (writes_rd & busy_ext[rd]);

        o_ex_valid = i_rst_n & ir_valid_q & !stall & !i_flush;
        fire       = o_ex_valid & i_ex_ready;
        o_if_ready = i_rst_n & !i_flush & (!ir_valid_q | fire);
        accept     = i_if_valid & o_if_ready;
    end

    always_comb begin
        o_r1addr      = rs1;
        o_r2addr      = rs2;
        o_ex_pc       = ir_pc_q;
        o_ex_rs1val   = i_r1data;
        o_ex_rs2val   = i_r2data;
        o_ex_imm      = imm;
        o_ex_rd       = writes_rd ? rd : 5'd0;
        o_ex_opcode   = opcode;
        o_ex_funct3   = ir_instr_q[14:12];
        o_ex_funct7b5 = ir_instr_q[30];
        o_ex_illegal  = !legal;
    end

    always_comb begin
        ir_instr_d = ir_instr_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        if (i_flush) begin
            ir_valid_d = 1'b0;
        end else if (accept) begin
            ir_instr_d = i_if_instr;
            ir_pc_d    = i_if_pc;
            ir_valid_d = 1'b1;
        end else if (fire) begin
            ir_valid_d = 1'b0;
        end
    end

    // Clear is applied before set so a same-cycle issue to the same register wins.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < 32; i++) begin
            if (i_wb_en && i_wb_rd == 5'(i)) begin
                busy_d[i] = 1'b0;
            end
            if (fire && writes_rd && rd == 5'(i)) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ir_instr_q <= 32'h0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            busy_q     <= '0;
        end else begin
            ir_instr_q <= ir_instr_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage with a small negedge register file model.
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        if_valid, if_ready;
    logic [31:0] if_instr, if_pc;
    logic [4:0]  r1addr, r2addr;
    logic [31:0] r1data, r2data;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_pc, ex_rs1val, ex_rs2val, ex_imm;
    logic [4:0]  ex_rd;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5, ex_illegal;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;

    logic [31:0] regs [32];
    int          errors = 0;
    int          checks = 0;

    decode_stage #(.XLEN(32)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_if_valid    (if_valid),
        .o_if_ready    (if_ready),
        .i_if_instr    (if_instr),
        .i_if_pc       (if_pc),
        .o_r1addr      (r1addr),
        .o_r2addr      (r2addr),
        .i_r1data      (r1data),
        .i_r2data      (r2data),
        .o_ex_valid    (ex_valid),
        .i_ex_ready    (ex_ready),
        .o_ex_pc       (ex_pc),
        .o_ex_rs1val   (ex_rs1val),
        .o_ex_rs2val   (ex_rs2val),
        .o_ex_imm      (ex_imm),
        .o_ex_rd       (ex_rd),
        .o_ex_opcode   (ex_opcode),
        .o_ex_funct3   (ex_funct3),
        .o_ex_funct7b5 (ex_funct7b5),
        .o_ex_illegal  (ex_illegal),
        .i_wb_en       (wb_en),
        .i_wb_rd       (wb_rd),
        .i_flush       (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: read and write at negedge, a same-edge read sees the old value.
    always @(negedge clk) begin
        r1data <= (r1addr == 5'd0) ? 32'h0 : regs[r1addr];
        r2data <= (r2addr == 5'd0) ? 32'h0 : regs[r2addr];
        if (wb_en && wb_rd != 5'd0) regs[wb_rd] <= wb_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        rst_n = 1'b0; if_valid = 1'b1; if_instr = 32'h0; if_pc = 32'h0;
        ex_ready = 1'b1; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'h0; flush = 1'b0;

        step();
        mid();
        check("rst_ex_valid", {31'h0, ex_valid}, 32'h0);
        check("rst_if_ready", {31'h0, if_ready}, 32'h0);

        // ADDI x1,x0,5
        step();
        rst_n = 1'b1; if_instr = 32'h00500093; if_pc = 32'h100;
        mid();
        check("post_rst_ex_valid", {31'h0, ex_valid}, 32'h0);
        check("post_rst_if_ready", {31'h0, if_ready}, 32'h1);

        // ADD x2,x1,x1
        step();
        if_instr = 32'h00108133; if_pc = 32'h104;
        mid();
        check("addi_valid", {31'h0, ex_valid}, 32'h1);
        check("addi_imm", ex_imm, 32'd5);
        check("addi_rd", {27'h0, ex_rd}, 32'd1);
        check("addi_pc", ex_pc, 32'h100);
        check("addi_opcode", {25'h0, ex_opcode}, 32'h13);
        check("addi_illegal", {31'h0, ex_illegal}, 32'h0);

        step();
        if_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            mid();
            check("raw_stall_valid", {31'h0, ex_valid}, 32'h0);
            check("raw_stall_if_ready", {31'h0, if_ready}, 32'h0);
            step();
        end
        check("add_r1addr", {27'h0, r1addr}, 32'd1);

        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
        mid();
        check("wb_cycle_still_stalled", {31'h0, ex_valid}, 32'h0);

        // BEQ x0,x0,-4 offered while ADD fires
        step();
        wb_en = 1'b0; if_valid = 1'b1; if_instr = 32'hFE000EE3; if_pc = 32'h108;
        mid();
        check("add_valid", {31'h0, ex_valid}, 32'h1);
        check("add_rs1val", ex_rs1val, 32'd5);
        check("add_rs2val", ex_rs2val, 32'd5);
        check("add_rd", {27'h0, ex_rd}, 32'd2);

        // ADDI x3,x0,7 waits behind the back-pressured branch
        step();
        if_instr = 32'h00700193; if_pc = 32'h10C; ex_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mid();
            check("beq_hold_valid", {31'h0, ex_valid}, 32'h1);
            check("beq_hold_imm", ex_imm, 32'hFFFFFFFC);
            check("beq_hold_pc", ex_pc, 32'h108);
            check("beq_hold_if_ready", {31'h0, if_ready}, 32'h0);
            step();
        end
        ex_ready = 1'b1;
        mid();
        check("beq_fire_rd", {27'h0, ex_rd}, 32'd0);
        check("beq_fire_if_ready", {31'h0, if_ready}, 32'h1);

        // ADDI x3 fires alongside a writeback of x3; ADD x4,x3,x0 accepted
        step();
        if_instr = 32'h00018233; if_pc = 32'h110;
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'd99;
        mid();
        check("addi3_valid", {31'h0, ex_valid}, 32'h1);
        check("addi3_imm", ex_imm, 32'd7);
        check("addi3_rd", {27'h0, ex_rd}, 32'd3);

        step();
        wb_en = 1'b0; if_valid = 1'b0;
        mid();
        check("set_wins_stall", {31'h0, ex_valid}, 32'h0);

        step();
        flush = 1'b1;
        mid();
        check("flush_ex_valid", {31'h0, ex_valid}, 32'h0);
        check("flush_if_ready", {31'h0, if_ready}, 32'h0);

        // Illegal opcode 0x7F
        step();
        flush = 1'b0; if_valid = 1'b1; if_instr = 32'h0000007F; if_pc = 32'h200;
        mid();
        check("post_flush_empty", {31'h0, ex_valid}, 32'h0);
        check("post_flush_if_ready", {31'h0, if_ready}, 32'h1);

        // ADD x5,x2,x0 follows; x2 still busy from the earlier ADD
        step();
        if_instr = 32'h000102B3; if_pc = 32'h204;
        mid();
        check("ill_valid", {31'h0, ex_valid}, 32'h1);
        check("ill_flag", {31'h0, ex_illegal}, 32'h1);
        check("ill_rd", {27'h0, ex_rd}, 32'd0);
        check("ill_imm", ex_imm, 32'h0);
        check("ill_opcode", {25'h0, ex_opcode}, 32'h7F);

        step();
        if_valid = 1'b0;
        mid();
        check("busy_kept_across_flush", {31'h0, ex_valid}, 32'h0);

        step();
        rst_n = 1'b0;
        mid();
        check("midstall_rst_valid", {31'h0, ex_valid}, 32'h0);
        check("midstall_rst_if_ready", {31'h0, if_ready}, 32'h0);

        step();
        rst_n = 1'b1; if_valid = 1'b1; if_instr = 32'h000102B3; if_pc = 32'h300;
        mid();
        check("rst2_ex_valid", {31'h0, ex_valid}, 32'h0);

        // LUI x6,0x12345
        step();
        if_instr = 32'h12345337; if_pc = 32'h304;
        mid();
        check("busy_cleared_valid", {31'h0, ex_valid}, 32'h1);
        check("add5_rd", {27'h0, ex_rd}, 32'd5);

        // SW x1,-8(x2)
        step();
        if_instr = 32'hFE112C23; if_pc = 32'h308;
        mid();
        check("lui_valid", {31'h0, ex_valid}, 32'h1);
        check("lui_imm", ex_imm, 32'h12345000);
        check("lui_rd", {27'h0, ex_rd}, 32'd6);

        // JAL x1,+8
        step();
        if_instr = 32'h008000EF; if_pc = 32'h30C;
        mid();
        check("sw_valid", {31'h0, ex_valid}, 32'h1);
        check("sw_imm", ex_imm, 32'hFFFFFFF8);
        check("sw_rd", {27'h0, ex_rd}, 32'd0);
        check("sw_rs2val", ex_rs2val, 32'd5);
        check("sw_funct3", {29'h0, ex_funct3}, 32'd2);

        step();
        if_valid = 1'b0;
        mid();
        check("jal_valid", {31'h0, ex_valid}, 32'h1);
        check("jal_imm", ex_imm, 32'd8);
        check("jal_rd", {27'h0, ex_rd}, 32'd1);

        step();
        mid();
        check("drained_valid", {31'h0, ex_valid}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
